// File: rtl/scan_timing_core.sv
// Scan timing core: waits a quarter period after each mirror zero-crossing,
// walks the point memory forward or in reverse, and fires per-channel laser
// pulses when the line time counter reaches each point's timestamp.
module scan_timing_core #(
   parameter int CNT_W   = 16,
   parameter int ADDR_W  = 11,
   parameter int N_CH    = 2,
   parameter int PULSE_W = 5
) (
   input  logic               clk_i,
   input  logic               nrst_i,
   input  logic               enable_i,
   input  logic               zc_i,
   input  logic               bidir_i,
   input  logic [ADDR_W-1:0]  points_per_line_i,
   input  logic [CNT_W-1:0]   quarter_delay_i,
   input  logic [PULSE_W-1:0] pulse_length_i,
   input  logic [N_CH-1:0]    ch_mask_i,
   output logic [ADDR_W-1:0]  raddr_o,
   input  logic [CNT_W-1:0]   ts_i,
   input  logic [N_CH-1:0]    active_i,
   output logic [N_CH-1:0]    laser_o,
   output logic               line_done_o,
   output logic               line_dir_o,
   output logic               overrun_o,
   output logic               busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      FETCH,
      DELAY,
      FIRE,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t             state_q;
   state_t             state_d;
   logic               zc_q;
   logic               zc_edge;
   logic [CNT_W-1:0]   counter_q;
   logic [ADDR_W-1:0]  index_q;
   logic [ADDR_W-1:0]  next_idx;
   logic [ADDR_W-1:0]  fetch_addr;
   logic [CNT_W-1:0]   ts_q;
   logic [N_CH-1:0]    active_q;
   logic               delay_first_q;
   logic [PULSE_W-1:0] pulse_cnt_q [N_CH];
   logic               start_line;
   logic               abort_line;
   logic               fire;
   logic               load_addr;

   assign zc_edge = zc_i & ~zc_q;

   // Next-state logic; any zero-crossing edge mid-line aborts straight to DONE
   always_comb begin
      state_d    = state_q;
      start_line = 1'b0;
      abort_line = 1'b0;
      fire       = 1'b0;
      load_addr  = 1'b0;
      if (!enable_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (zc_edge && (points_per_line_i != '0)) begin
                  state_d    = WAIT;
                  start_line = 1'b1;
               end
            end
            WAIT: begin
               if (zc_edge) begin
                  abort_line = 1'b1;
               end else if (counter_q >= quarter_delay_i) begin
                  state_d   = FETCH;
                  load_addr = 1'b1;
               end
            end
            FETCH: begin
               if (zc_edge) begin
                  abort_line = 1'b1;
               end else begin
                  state_d = DELAY;
               end
            end
            DELAY: begin
               if (zc_edge) begin
                  abort_line = 1'b1;
               end else if (!delay_first_q && (counter_q >= ts_q)) begin
                  state_d = FIRE;
               end
            end
            FIRE: begin
               if (zc_edge) begin
                  abort_line = 1'b1;
               end else begin
                  fire = 1'b1;
                  if (index_q == (points_per_line_i - ADDR_W'(1))) begin
                     state_d = DONE;
                  end else begin
                     state_d   = FETCH;
                     load_addr = 1'b1;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
         if (abort_line) begin
            state_d = DONE;
         end
      end
   end

   // Address of the point about to be fetched, mirrored on reverse lines
   always_comb begin
      next_idx   = (state_q == FIRE) ? index_q + ADDR_W'(1) : index_q;
      fetch_addr = line_dir_o ? (points_per_line_i - ADDR_W'(1) - next_idx) : next_idx;
   end

   // State register and zero-crossing input register
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= IDLE;
         zc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         zc_q    <= zc_i;
      end
   end

   // Line time counter: cleared at line start, saturates instead of wrapping
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         counter_q <= '0;
      end else if (start_line) begin
         counter_q <= '0;
      end else if ((state_q != IDLE) && (counter_q != CNT_MAX)) begin
         counter_q <= counter_q + CNT_W'(1);
      end
   end

   // Point index and registered memory read address
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         index_q <= '0;
         raddr_o <= '0;
      end else begin
         if (start_line) begin
            index_q <= '0;
         end else if (fire) begin
            index_q <= index_q + ADDR_W'(1);
         end
         if (load_addr) begin
            raddr_o <= fetch_addr;
         end
      end
   end

   // Capture timestamp and active bits on the first DELAY cycle, when memory data is valid
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         delay_first_q <= 1'b0;
         ts_q          <= '0;
         active_q      <= '0;
      end else begin
         delay_first_q <= (state_q == FETCH);
         if ((state_q == DELAY) && delay_first_q) begin
            ts_q     <= ts_i;
            active_q <= active_i;
         end
      end
   end

   // Line direction toggles at each line end in bidirectional mode; overrun flags an abort
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         line_dir_o <= 1'b0;
         overrun_o  <= 1'b0;
      end else begin
         overrun_o <= abort_line;
         if (state_q == DONE) begin
            line_dir_o <= bidir_i ? ~line_dir_o : 1'b0;
         end
      end
   end

   // Per-channel pulse counters; a new FIRE reloads a running pulse seamlessly
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         for (int c = 0; c < N_CH; c++) begin
            pulse_cnt_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (fire && active_q[c] && ch_mask_i[c]) begin
               pulse_cnt_q[c] <= pulse_length_i;
            end else if (pulse_cnt_q[c] != '0) begin
               pulse_cnt_q[c] <= pulse_cnt_q[c] - PULSE_W'(1);
            end
         end
      end
   end

   // Laser outputs follow the pulse counters, so reset clears them at once
   always_comb begin
      laser_o = '0;
      for (int c = 0; c < N_CH; c++) begin
         laser_o[c] = (pulse_cnt_q[c] != '0);
      end
   end

   assign line_done_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);

endmodule
